// File: rtl/ps2_key_serializer.sv
// PS/2 device-side serializer: hps_io ps2_key events -> set-2 byte frames.
// Define PS2_INHIBIT_EN to add the host inhibit input (hold off / abort frames).
module ps2_key_serializer #(
    parameter int HALF_DIV   = 1145,
    parameter int GAP_CYC    = 2290,
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic        ps2_clk,
    output logic        ps2_data,
    output logic        busy,
    output logic        overflow
`ifdef PS2_INHIBIT_EN
    ,
    input  logic        inhibit
`endif
);
    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int CMAX = (HALF_DIV > GAP_CYC) ? HALF_DIV : GAP_CYC;
    localparam int CW   = $clog2(CMAX + 1);

    localparam logic [1:0] EV_IDLE = 2'd0;
    localparam logic [1:0] EV_E0   = 2'd1;
    localparam logic [1:0] EV_F0   = 2'd2;
    localparam logic [1:0] EV_CODE = 2'd3;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LOAD = 3'd1;
    localparam logic [2:0] S_HIGH = 3'd2;
    localparam logic [2:0] S_LOW  = 3'd3;
    localparam logic [2:0] S_GAP  = 3'd4;
    localparam logic [2:0] S_INH  = 3'd5;

    localparam logic [CW-1:0] HALF_LD = CW'(HALF_DIV - 1);
    localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW:0]   PTR_ONE = (AW+1)'(1);
    localparam logic [AW+1:0] DEPTH_W = (AW+2)'(FIFO_DEPTH);

    logic inh;
`ifdef PS2_INHIBIT_EN
    assign inh = inhibit;
`else
    assign inh = 1'b0;
`endif

    logic          armed;
    logic          prev_toggle;
    logic [1:0]    ev_state;
    logic [7:0]    ev_code;
    logic          ev_rel;
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level;
    logic [7:0]    fifo_mem [FIFO_DEPTH];
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [7:0]    push_byte;
    logic [1:0]    n_bytes;
    logic [AW+1:0] need;
    logic          detect;
    logic          drop;

    assign level      = wr_ptr - rd_ptr;
    assign fifo_empty = (level == '0);
    assign n_bytes    = 2'd1 + {1'b0, ps2_key[8]} + {1'b0, ~ps2_key[9]};
    assign need       = {1'b0, level} + {{AW{1'b0}}, n_bytes};
    assign detect     = armed && (ps2_key[10] != prev_toggle)
                        && (ev_state == EV_IDLE);
    // An event is admitted only if all of its bytes fit right now
    assign drop       = need > DEPTH_W;
    assign push       = (ev_state != EV_IDLE);
    assign push_byte  = (ev_state == EV_E0) ? 8'hE0 :
                        (ev_state == EV_F0) ? 8'hF0 : ev_code;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed       <= 1'b0;
            prev_toggle <= 1'b0;
            ev_state    <= EV_IDLE;
            ev_code     <= 8'h00;
            ev_rel      <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (!armed) begin
                armed       <= 1'b1;
                prev_toggle <= ps2_key[10];
            end else if (detect) begin
                prev_toggle <= ps2_key[10];
                if (drop) begin
                    overflow <= 1'b1;
                end else begin
                    ev_code  <= ps2_key[7:0];
                    ev_rel   <= ~ps2_key[9];
                    ev_state <= ps2_key[8] ? EV_E0 :
                                (!ps2_key[9] ? EV_F0 : EV_CODE);
                end
            end else begin
                unique case (ev_state)
                    EV_E0:   ev_state <= ev_rel ? EV_F0 : EV_CODE;
                    EV_F0:   ev_state <= EV_CODE;
                    EV_CODE: ev_state <= EV_IDLE;
                    default: ev_state <= EV_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk_sys) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= push_byte;
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    logic [2:0]    ser_state;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [10:0]   shreg;
    logic [7:0]    cur_byte;
    logic          cnt_done;
    logic          abort;

    assign pop      = (ser_state == S_IDLE) && !fifo_empty && !inh;
    assign cnt_done = (cnt == '0);
    // The stop bit is never aborted; cur_byte is kept for a resend
    assign abort    = inh && (bit_idx != 4'd10);

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            ser_state <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= 4'd0;
            shreg     <= '1;
            cur_byte  <= 8'h00;
        end else begin
            unique case (ser_state)
                S_IDLE: begin
                    if (pop) begin
                        cur_byte  <= fifo_mem[rd_ptr[AW-1:0]];
                        ser_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    shreg     <= {1'b1, ~^cur_byte, cur_byte, 1'b0};
                    bit_idx   <= 4'd0;
                    cnt       <= HALF_LD;
                    ser_state <= S_HIGH;
                end
                S_HIGH: begin
                    if (abort) begin
                        cnt       <= GAP_LD;
                        ser_state <= S_INH;
                    end else if (cnt_done) begin
                        cnt       <= HALF_LD;
                        ser_state <= S_LOW;
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_LOW: begin
                    if (abort) begin
                        cnt       <= GAP_LD;
                        ser_state <= S_INH;
                    end else if (cnt_done) begin
                        if (bit_idx == 4'd10) begin
                            cnt       <= GAP_LD;
                            ser_state <= S_GAP;
                        end else begin
                            bit_idx   <= bit_idx + 4'd1;
                            shreg     <= {1'b1, shreg[10:1]};
                            cnt       <= HALF_LD;
                            ser_state <= S_HIGH;
                        end
                    end else begin
                        cnt <= cnt - CNT_ONE;
                    end
                end
                S_GAP: begin
                    if (cnt_done) ser_state <= S_IDLE;
                    else          cnt <= cnt - CNT_ONE;
                end
                S_INH: begin
                    if (inh)           cnt <= GAP_LD;
                    else if (cnt_done) ser_state <= S_LOAD;
                    else               cnt <= cnt - CNT_ONE;
                end
                default: ser_state <= S_IDLE;
            endcase
        end
    end

    assign ps2_clk  = (ser_state != S_LOW);
    assign ps2_data = ((ser_state == S_HIGH) || (ser_state == S_LOW))
                      ? shreg[0] : 1'b1;
    assign busy     = !fifo_empty || (ser_state != S_IDLE)
                      || (ev_state != EV_IDLE);

endmodule

// File: tb/tb_ps2_key_serializer.sv
// Bench for ps2_key_serializer: random key events against a byte/occupancy
// reference model, with a line-level PS/2 receiver checking every frame.
module tb_ps2_key_serializer;
    localparam int H = 4;
    localparam int G = 8;
    localparam int D = 8;
    // pop cycle to next possible pop: LOAD + 22 half periods + gap + IDLE
    localparam int SLOT = 2 + 22*H + G;

    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = '0;
    logic        ps2_clk;
    logic        ps2_data;
    logic        busy;
    logic        overflow;
`ifdef PS2_INHIBIT_EN
    logic        inhibit = 1'b0;
`endif

    int errors = 0;
    int checks = 0;

    ps2_key_serializer #(.HALF_DIV(H), .GAP_CYC(G), .FIFO_DEPTH(D)) dut (
        .clk_sys (clk_sys),
        .reset_n (reset_n),
        .ps2_key (ps2_key),
        .ps2_clk (ps2_clk),
        .ps2_data(ps2_data),
        .busy    (busy),
        .overflow(overflow)
`ifdef PS2_INHIBIT_EN
        ,
        .inhibit (inhibit)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // reference model: FIFO occupancy, event admission, expected byte order
    logic [7:0] exp_q[$];
    int  m_level, m_pend, m_free, cyc, m_drops, m_n;
    bit  m_armed, m_prev, m_ovf, m_busy, m_push, m_pop;
    bit  chk_busy = 1'b1;

    always @(posedge clk_sys) begin
        if (!reset_n) begin
            m_armed = 0; m_prev = 0; m_level = 0; m_pend = 0;
            m_free = 0; cyc = 0; m_ovf = 0; m_busy = 0;
            exp_q.delete();
        end else begin
            m_ovf  = 0;
            m_pop  = (m_level > 0) && (cyc >= m_free);
            if (m_pop) m_free = cyc + SLOT;
            m_push = (m_pend > 0);
            if (m_push) m_pend--;
            if (!m_armed) begin
                m_armed = 1;
                m_prev  = ps2_key[10];
            end else if (ps2_key[10] != m_prev && !m_push) begin
                m_prev = ps2_key[10];
                m_n = 1 + int'(ps2_key[8]) + int'(!ps2_key[9]);
                if (D - m_level < m_n) begin
                    m_ovf = 1;
                    m_drops++;
                end else begin
                    if (ps2_key[8])  exp_q.push_back(8'hE0);
                    if (!ps2_key[9]) exp_q.push_back(8'hF0);
                    exp_q.push_back(ps2_key[7:0]);
                    m_pend = m_n;
                end
            end
            m_level = m_level + int'(m_push) - int'(m_pop);
            cyc++;
            m_busy = (m_level > 0) || (m_pend > 0) || (cyc < m_free);
        end
    end

    // receiver: samples lines between edges, decodes frames on falling clk
    int frames = 0, aborts = 0, ovf_seen = 0;
    int hi_run = 1000, lo_run = 0, bitcnt = 0;
    logic [10:0] frm;
    logic [7:0]  e_byte;
    logic [8:0]  rx_q[$];
    int          gap_q[$];
    bit pclk = 1'b1, pdata = 1'b1;

    always @(negedge clk_sys) begin
        if (!reset_n) begin
            bitcnt = 0; hi_run = 1000; lo_run = 0; pclk = 1; pdata = 1;
        end else begin
            if (chk_busy) begin
                checks++;
                if (busy !== m_busy) begin
                    errors++;
                    $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, m_busy);
                end
            end
            checks++;
            if (overflow !== m_ovf) begin
                errors++;
                $display("FAIL overflow cyc=%0d got=%b exp=%b", cyc, overflow, m_ovf);
            end
            if (overflow === 1'b1) ovf_seen++;
            if (ps2_clk === 1'b1) begin
                if (!pclk) begin
                    checks++;
                    if (lo_run != H) begin
                        errors++;
                        $display("FAIL clk_low_len got=%0d exp=%0d", lo_run, H);
                    end
                    hi_run = 0;
                end
                hi_run++;
                if (bitcnt > 0 && hi_run > H) begin
                    aborts++;
                    bitcnt = 0;
                end
            end else begin
                if (pclk) begin
                    checks++;
                    if ((bitcnt == 0) ? (hi_run < G + H + 1) : (hi_run != H)) begin
                        errors++;
                        $display("FAIL clk_high_len bit=%0d got=%0d", bitcnt, hi_run);
                    end
                    if (bitcnt == 0) gap_q.push_back(hi_run);
                    frm[bitcnt] = ps2_data;
                    bitcnt++;
                    lo_run = 0;
                    if (bitcnt == 11) begin
                        bitcnt = 0;
                        frames++;
                        checks++;
                        if (frm[0] !== 1'b0 || frm[10] !== 1'b1) begin
                            errors++;
                            $display("FAIL framing got=%b exp=start0 stop1", frm);
                        end
                        checks++;
                        if (frm[9] !== ~^frm[8:1]) begin
                            errors++;
                            $display("FAIL parity byte=%h got=%b exp=%b",
                                     frm[8:1], frm[9], ~^frm[8:1]);
                        end
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL rx_byte got=%h exp=none", frm[8:1]);
                        end else begin
                            e_byte = exp_q.pop_front();
                            if (frm[8:1] !== e_byte) begin
                                errors++;
                                $display("FAIL rx_byte got=%h exp=%h", frm[8:1], e_byte);
                            end
                        end
                        rx_q.push_back(frm[9:1]);
                    end
                end else begin
                    checks++;
                    if (ps2_data !== pdata) begin
                        errors++;
                        $display("FAIL data_while_low got=%b exp=%b", ps2_data, pdata);
                    end
                end
                lo_run++;
            end
            pclk  = ps2_clk;
            pdata = ps2_data;
        end
    end

    task automatic send_event(input bit pressed, input bit ext, input logic [7:0] code);
        @(posedge clk_sys); #1;
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    task automatic wait_idle(input int max, output bit ok);
        ok = 0;
        repeat (3) @(negedge clk_sys);
        for (int i = 0; i < max; i++) begin
            @(negedge clk_sys);
            if (!busy && exp_q.size() == 0 && m_pend == 0) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset_n = 0;
        ps2_key = 11'h400;
        repeat (3) @(negedge clk_sys);
        checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL rst_clk got=%b exp=1", ps2_clk); end
        checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL rst_data got=%b exp=1", ps2_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got=%b exp=0", overflow); end
        @(posedge clk_sys); #1;
        reset_n = 1;
        repeat (40) @(negedge clk_sys);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arm_busy got=%b exp=0", busy); end
        checks++; if (frames != 0) begin errors++; $display("FAIL arm_frames got=%0d exp=0", frames); end
    endtask

    task automatic test_make;
        bit ok;
        rx_q.delete();
        send_event(1'b1, 1'b0, 8'h1C);
        wait_idle(400, ok);
        checks++; if (!ok) begin errors++; $display("FAIL make_timeout got=busy exp=idle"); end
        checks++;
        if (rx_q.size() != 1 || rx_q[0] !== 9'h01C) begin
            errors++;
            $display("FAIL make_frame got_n=%0d exp={0,1C}", rx_q.size());
        end
    endtask

    task automatic test_ext_break;
        bit ok;
        logic [8:0] ev[3];
        ev[0] = 9'h0E0; ev[1] = 9'h1F0; ev[2] = 9'h075;
        rx_q.delete();
        gap_q.delete();
        send_event(1'b0, 1'b1, 8'h75);
        wait_idle(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL brk_timeout got=busy exp=idle"); end
        checks++;
        if (rx_q.size() != 3) begin
            errors++;
            $display("FAIL brk_count got=%0d exp=3", rx_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rx_q[i] !== ev[i]) begin
                    errors++;
                    $display("FAIL brk_byte%0d got=%h exp=%h", i, rx_q[i], ev[i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (gap_q[i] != G + 2 + H) begin
                    errors++;
                    $display("FAIL brk_gap%0d got=%0d exp=%0d", i, gap_q[i], G + 2 + H);
                end
            end
        end
    endtask

    task automatic test_overflow;
        bit ok;
        int d0, o0;
        d0 = m_drops;
        o0 = ovf_seen;
        rx_q.delete();
        for (int i = 0; i < 7; i++) begin
            send_event(1'b0, 1'b1, 8'($urandom_range(1, 255)));
            repeat (3) @(posedge clk_sys);
        end
        wait_idle(3000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL ovf_timeout got=busy exp=idle"); end
        checks++;
        if (ovf_seen - o0 != 4) begin
            errors++;
            $display("FAIL ovf_pulses got=%0d exp=4", ovf_seen - o0);
        end
        checks++;
        if (m_drops - d0 != 4) begin
            errors++;
            $display("FAIL ovf_model_drops got=%0d exp=4", m_drops - d0);
        end
        checks++;
        if (rx_q.size() != 9) begin
            errors++;
            $display("FAIL ovf_bytes got=%0d exp=9", rx_q.size());
        end else begin
            for (int i = 0; i < 9; i += 3) begin
                checks++;
                if (rx_q[i][7:0] !== 8'hE0 || rx_q[i+1][7:0] !== 8'hF0) begin
                    errors++;
                    $display("FAIL ovf_event%0d got=%h,%h exp=E0,F0",
                             i / 3, rx_q[i][7:0], rx_q[i+1][7:0]);
                end
            end
        end
    endtask

    task automatic test_random;
        bit ok;
        int d0, o0;
        d0 = m_drops;
        o0 = ovf_seen;
        for (int i = 0; i < 40; i++) begin
            send_event(1'($urandom), 1'($urandom), 8'($urandom));
            repeat ($urandom_range(0, 150)) @(posedge clk_sys);
        end
        wait_idle(8000, ok);
        checks++; if (!ok) begin errors++; $display("FAIL rnd_timeout got=busy exp=idle"); end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL rnd_pending got=%0d exp=0", exp_q.size());
        end
        checks++;
        if (ovf_seen - o0 != m_drops - d0) begin
            errors++;
            $display("FAIL rnd_drops got=%0d exp=%0d", ovf_seen - o0, m_drops - d0);
        end
        checks++;
        if (aborts != 0) begin
            errors++;
            $display("FAIL rnd_aborts got=%0d exp=0", aborts);
        end
    endtask

    task automatic test_reset_mid;
        int f0;
        bit hit;
        f0 = frames;
        hit = 0;
        send_event(1'b1, 1'b0, 8'h1C);
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk_sys);
            if (bitcnt == 6 && ps2_clk === 1'b0) hit = 1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL rmid_reach got=no_bit5 exp=bit5");
        end
        @(posedge clk_sys); #1;
        reset_n = 0;
        #1;
        checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL rmid_clk got=%b exp=1", ps2_clk); end
        checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL rmid_data got=%b exp=1", ps2_data); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_busy got=%b exp=0", busy); end
        repeat (3) @(posedge clk_sys);
        #1;
        reset_n = 1;
        repeat (300) @(negedge clk_sys);
        checks++; if (frames != f0) begin errors++; $display("FAIL rmid_frames got=%0d exp=%0d", frames, f0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rmid_idle got=%b exp=0", busy); end
    endtask

`ifdef PS2_INHIBIT_EN
    task automatic test_inhibit;
        bit ok, hit;
        int f0, a0;
        f0 = frames;
        a0 = aborts;
        hit = 0;
        chk_busy = 0;
        rx_q.delete();
        send_event(1'b1, 1'b0, 8'h1C);
        for (int i = 0; i < 400 && !hit; i++) begin
            @(negedge clk_sys);
            if (bitcnt == 4 && ps2_clk === 1'b1) hit = 1;
        end
        checks++; if (!hit) begin errors++; $display("FAIL inh_reach got=no_bit4 exp=bit4"); end
        @(posedge clk_sys); #1;
        inhibit = 1;
        repeat (3) @(negedge clk_sys);
        checks++; if (ps2_clk !== 1'b1) begin errors++; $display("FAIL inh_clk got=%b exp=1", ps2_clk); end
        checks++; if (ps2_data !== 1'b1) begin errors++; $display("FAIL inh_data got=%b exp=1", ps2_data); end
        repeat (20) @(posedge clk_sys);
        #1;
        inhibit = 0;
        wait_idle(600, ok);
        checks++; if (!ok) begin errors++; $display("FAIL inh_timeout got=busy exp=idle"); end
        checks++; if (aborts - a0 != 1) begin errors++; $display("FAIL inh_aborts got=%0d exp=1", aborts - a0); end
        checks++;
        if (frames - f0 != 1 || rx_q.size() != 1 || rx_q[0] !== 9'h01C) begin
            errors++;
            $display("FAIL inh_resend got_frames=%0d exp=1 of {0,1C}", frames - f0);
        end
        chk_busy = 1;
    endtask
`endif

    initial begin
        #900000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_make();
        test_ext_break();
        test_overflow();
        test_random();
        test_reset_mid();
`ifdef PS2_INHIBIT_EN
        test_inhibit();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
